retire_ctrl: RTL and testbench

RETIRE_CTRL -- requirements
Module: retire_ctrl

---
 rtl/retire_ctrl.sv | 122 ++++++++++++
 tb/tb_retire_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/retire_ctrl.sv
// Retirement controller: picks how many ROB head slots commit each cycle and
// sequences the flush and halt outcomes that a retiring head can trigger.
module retire_ctrl #(
  parameter int N      = 3,
  parameter int CNT_W  = $clog2(N+1),
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CNT_W-1:0]    head_valid_cnt,
  input  logic [N-1:0]        head_complete,
  input  logic [N-1:0]        head_exception,
  input  logic [N-1:0]        head_halt,
  input  logic [N-1:0]        head_is_store,
  input  logic [N-1:0]        head_has_dest,
  input  logic [N*AREG_W-1:0] head_areg,
  input  logic [N*PREG_W-1:0] head_preg,
  input  logic [N*PREG_W-1:0] head_old_preg,
  input  logic                store_ready,
  input  logic                retire_stall,
  output logic [CNT_W-1:0]    num_retiring,
  output logic [N-1:0]        amap_we,
  output logic [N*AREG_W-1:0] amap_areg,
  output logic [N*PREG_W-1:0] amap_preg,
  output logic [N-1:0]        free_valid,
  output logic                store_commit,
  output logic                flush,
  output logic                halted,
  output logic [31:0]         retired_total
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t             state_q, state_d;
  logic               flush_q, flush_d;
  logic               halted_q, halted_d;
  logic [31:0]        retired_total_q, retired_total_d;

  logic [CNT_W-1:0]   valid_n;
  logic [CNT_W-1:0]   k;
  logic [N-1:0]       we;
  logic               open;
  logic               seen_store;
  logic               take_exc;
  logic               take_halt;

  // The free list consumes head_old_preg directly; free_valid is the only qualifier.
  logic unused_old_preg;
  assign unused_old_preg = ^head_old_preg;

  // Walk the head oldest-first; the prefix closes at the first slot that cannot
  // retire, and a halt closes it right after being included.
  always_comb begin
    valid_n    = (head_valid_cnt > CNT_W'(N)) ? CNT_W'(N) : head_valid_cnt;
    k          = '0;
    we         = '0;
    seen_store = 1'b0;
    take_exc   = 1'b0;
    take_halt  = 1'b0;
    open       = (state_q == RUN) && !retire_stall;
    for (int i = 0; i < N; i++) begin
      if (open) begin
        if (CNT_W'(i) >= valid_n || !head_complete[i]) begin
          open = 1'b0;
        end else if (head_exception[i]) begin
          open     = 1'b0;
          take_exc = 1'b1;
        end else if (head_is_store[i] && (seen_store || !store_ready)) begin
          open = 1'b0;
        end else begin
          k     = k + CNT_W'(1);
          we[i] = head_has_dest[i];
          if (head_is_store[i]) seen_store = 1'b1;
          if (head_halt[i]) begin
            take_halt = 1'b1;
            open      = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (take_halt) state_d = HALTED;
               else if (take_exc) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    flush_d         = (state_d == FLUSH);
    halted_d        = (state_d == HALTED);
    retired_total_d = retired_total_q + 32'(k);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= RUN;
      flush_q         <= 1'b0;
      halted_q        <= 1'b0;
      retired_total_q <= '0;
    end else begin
      state_q         <= state_d;
      flush_q         <= flush_d;
      halted_q        <= halted_d;
      retired_total_q <= retired_total_d;
    end
  end

  assign num_retiring  = k;
  assign amap_we       = we;
  assign free_valid    = we;
  assign amap_areg     = head_areg;
  assign amap_preg     = head_preg;
  assign store_commit  = seen_store;
  assign flush         = flush_q;
  assign halted        = halted_q;
  assign retired_total = retired_total_q;

endmodule

// File: tb/tb_retire_ctrl.sv
// Bench for retire_ctrl: a prefix-rule model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_retire_ctrl;
  localparam int N = 3, CNT_W = 2, AW = 5, PW = 6;
  localparam int M_RUN = 0, M_FLUSH = 1, M_HALTED = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [CNT_W-1:0]  head_valid_cnt;
  logic [N-1:0]      head_complete, head_exception, head_halt, head_is_store, head_has_dest;
  logic [N*AW-1:0]   head_areg;
  logic [N*PW-1:0]   head_preg, head_old_preg;
  logic              store_ready, retire_stall;
  logic [CNT_W-1:0]  num_retiring;
  logic [N-1:0]      amap_we, free_valid;
  logic [N*AW-1:0]   amap_areg;
  logic [N*PW-1:0]   amap_preg;
  logic              store_commit, flush, halted;
  logic [31:0]       retired_total;

  retire_ctrl #(.N(N), .CNT_W(CNT_W), .AREG_W(AW), .PREG_W(PW)) dut (
    .clock(clock), .reset(reset), .head_valid_cnt(head_valid_cnt),
    .head_complete(head_complete), .head_exception(head_exception), .head_halt(head_halt),
    .head_is_store(head_is_store), .head_has_dest(head_has_dest), .head_areg(head_areg),
    .head_preg(head_preg), .head_old_preg(head_old_preg), .store_ready(store_ready),
    .retire_stall(retire_stall), .num_retiring(num_retiring), .amap_we(amap_we),
    .amap_areg(amap_areg), .amap_preg(amap_preg), .free_valid(free_valid),
    .store_commit(store_commit), .flush(flush), .halted(halted), .retired_total(retired_total)
  );

  always #5 clock = ~clock;

  int total_n = 0;
  int bad_n   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: mode and running total, advanced on each posedge.
  int          m_mode = M_RUN;
  logic [31:0] m_total = '0;
  bit          m_live = 1'b0;

  function automatic void model(output int k, output logic [N-1:0] we, output logic st,
                                output logic exc, output logic hlt);
    int lim;
    int stores;
    lim = (int'(head_valid_cnt) > N) ? N : int'(head_valid_cnt);
    stores = 0;
    k = 0; we = '0; st = 1'b0; exc = 1'b0; hlt = 1'b0;
    if (m_mode != M_RUN || retire_stall) return;
    for (int i = 0; i < lim; i++) begin
      if (!head_complete[i]) break;
      if (head_exception[i]) begin exc = 1'b1; break; end
      if (head_is_store[i]) begin
        if (stores == 1 || !store_ready) break;
        stores++;
      end
      we[i] = head_has_dest[i];
      k++;
      if (head_halt[i]) begin hlt = 1'b1; break; end
    end
    st = (stores > 0);
  endfunction

  always @(posedge clock) begin
    int k; logic [N-1:0] we; logic st, e, h;
    if (reset) begin
      m_mode = M_RUN; m_total = '0; m_live = 1'b1;
    end else if (m_live) begin
      model(k, we, st, e, h);
      m_total = m_total + 32'(k);
      if (m_mode == M_RUN) m_mode = h ? M_HALTED : (e ? M_FLUSH : M_RUN);
      else if (m_mode == M_FLUSH) m_mode = M_RUN;
    end
  end

  always @(negedge clock) begin
    int k; logic [N-1:0] we; logic st, e, h;
    if (m_live) begin
      model(k, we, st, e, h);
      chk("m_num_retiring", 64'(num_retiring), 64'(k));
      chk("m_amap_we", 64'(amap_we), 64'(we));
      chk("m_free_valid", 64'(free_valid), 64'(we));
      chk("m_store_commit", 64'(store_commit), 64'(st));
      chk("m_flush", 64'(flush), 64'(m_mode == M_FLUSH));
      chk("m_halted", 64'(halted), 64'(m_mode == M_HALTED));
      chk("m_retired_total", 64'(retired_total), 64'(m_total));
      chk("m_amap_areg", 64'(amap_areg), 64'(head_areg));
      chk("m_amap_preg", 64'(amap_preg), 64'(head_preg));
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic [CNT_W-1:0] cnt, input logic [N-1:0] comp, input logic [N-1:0] exc,
                       input logic [N-1:0] hlt, input logic [N-1:0] st, input logic [N-1:0] dst,
                       input logic sr, input logic stall);
    head_valid_cnt = cnt; head_complete = comp; head_exception = exc; head_halt = hlt;
    head_is_store = st; head_has_dest = dst; store_ready = sr; retire_stall = stall;
    head_areg = N*AW'($urandom); head_preg = N*PW'($urandom); head_old_preg = N*PW'($urandom);
  endtask

  task automatic idle();
    drive(2'd0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step(); step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_total", 64'(retired_total), 64'd0);

    // Full-width retire.
    step(); drive(2'd3, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("all3_k", 64'(num_retiring), 64'd3);
    chk("all3_we", 64'(amap_we), 64'b111);
    chk("all3_free", 64'(free_valid), 64'b111);
    step(); idle();
    @(negedge clock);
    chk("all3_total", 64'(retired_total), 64'd3);

    // Hole at slot 1.
    step(); drive(2'd3, 3'b101, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("hole_k", 64'(num_retiring), 64'd1);
    chk("hole_we", 64'(amap_we), 64'b001);

    // Store gating.
    step(); drive(2'd3, 3'b111, 3'b000, 3'b000, 3'b011, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("st_rdy_k", 64'(num_retiring), 64'd1);
    chk("st_rdy_commit", 64'(store_commit), 64'd1);
    step(); drive(2'd3, 3'b111, 3'b000, 3'b000, 3'b011, 3'b111, 1'b0, 1'b0);
    @(negedge clock);
    chk("st_nrdy_k", 64'(num_retiring), 64'd0);
    chk("st_nrdy_commit", 64'(store_commit), 64'd0);

    // Stall, empty head, oldest incomplete, partial valid count.
    step(); drive(2'd3, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1);
    @(negedge clock);
    chk("stall_k", 64'(num_retiring), 64'd0);
    chk("stall_we", 64'(amap_we), 64'd0);
    step(); drive(2'd0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("empty_k", 64'(num_retiring), 64'd0);
    step(); drive(2'd3, 3'b110, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("old_incomplete_k", 64'(num_retiring), 64'd0);
    step(); drive(2'd2, 3'b111, 3'b000, 3'b000, 3'b000, 3'b101, 1'b1, 1'b0);
    @(negedge clock);
    chk("cnt2_k", 64'(num_retiring), 64'd2);
    chk("cnt2_we", 64'(amap_we), 64'b001);

    // Exception on slot 1 -> one-cycle flush.
    step(); drive(2'd3, 3'b111, 3'b010, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("exc_k", 64'(num_retiring), 64'd1);
    chk("exc_flush0", 64'(flush), 64'd0);
    step(); drive(2'd3, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("exc_flush1", 64'(flush), 64'd1);
    chk("exc_flush_k", 64'(num_retiring), 64'd0);
    step(); idle();
    @(negedge clock);
    chk("exc_flush2", 64'(flush), 64'd0);
    chk("exc_run_halted", 64'(halted), 64'd0);

    // Counter wrap from a preloaded value.
    step(); idle();
    force dut.retired_total_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_total_q;
    m_total = 32'hFFFF_FFFE;
    @(negedge clock);
    chk("wrap_preload", 64'(retired_total), 64'hFFFF_FFFE);
    step(); drive(2'd3, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    step(); idle();
    @(negedge clock);
    chk("wrap_total", 64'(retired_total), 64'h0000_0001);

    // Halt on slot 1.
    step(); drive(2'd3, 3'b111, 3'b000, 3'b010, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("halt_k", 64'(num_retiring), 64'd2);
    chk("halt_we", 64'(amap_we), 64'b011);
    step(); drive(2'd3, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    @(negedge clock);
    chk("halted1", 64'(halted), 64'd1);
    chk("halted_k", 64'(num_retiring), 64'd0);
    step();
    @(negedge clock);
    chk("halted_hold_k", 64'(num_retiring), 64'd0);
    chk("halted_total", 64'(retired_total), 64'd3);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clock);
    chk("post_rst_halted", 64'(halted), 64'd0);
    chk("post_rst_total", 64'(retired_total), 64'd0);
    chk("post_rst_k", 64'(num_retiring), 64'd3);

    step(); idle();
    step();
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
